// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, FSM states and address-channel bundle
// for the SRAM responder and its burst address generator.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_BURST
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_WAIT,
    W_RESP
  } w_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_t;

  // Response codes are ordered so the numerically larger one is worse.
  function automatic logic [1:0] resp_max(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-beat address decode: word index, response class and the
// address of the following beat for FIXED and INCR bursts.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          IW        = $clog2(DEPTH)
) (
  input  logic [31:0]   addr_i,
  input  logic [2:0]    size_i,
  input  logic [1:0]    burst_i,
  output logic [31:0]   next_o,
  output logic [IW-1:0] idx_o,
  output logic [1:0]    resp_o
);

  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  logic [31:0] off;
  logic        in_range;
  logic        bad_fmt;

  always_comb begin
    off      = addr_i - BASE_ADDR;
    in_range = (addr_i >= BASE_ADDR) && (off < SPAN);
    bad_fmt  = (size_i > 3'd2) ||
               (burst_i == BURST_WRAP) ||
               (burst_i == 2'b11);
    idx_o    = off[IW+1:2];
    next_o   = addr_i;
    if (burst_i != BURST_FIXED)
      next_o = addr_i + (32'd1 << size_i);
    // A malformed request is a slave error even when also out of range.
    if (bad_fmt)
      resp_o = RESP_SLVERR;
    else if (!in_range)
      resp_o = RESP_DECERR;
    else
      resp_o = RESP_OKAY;
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 SRAM responder with independent read and write FSMs.
// Define AXI4_SRAM_SLAVE_RAND_DELAY_EN for LFSR handshake gaps.
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          READ_LAT  = 1,
  parameter int          WRITE_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int         IW   = $clog2(DEPTH);
  localparam logic [7:0] RLAT = 8'(READ_LAT);
  localparam logic [7:0] WLAT = 8'(WRITE_LAT);

  logic [31:0] mem_q [DEPTH];
  logic [2:0]  gap;

`ifdef AXI4_SRAM_SLAVE_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign gap = lfsr_q[2:0];
`else
  assign gap = 3'd0;
`endif

  // ---------------- read channel ----------------
  r_state_e    r_state_q, r_state_d;
  ax_t         rax_q, rax_d;
  logic [7:0]  rbeat_q, rbeat_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        r_load;
  logic [31:0] r_next;
  logic [IW-1:0] r_idx;
  logic [1:0]  r_resp;

  axi4_burst_addr_gen #(
    .BASE_ADDR(BASE_ADDR),
    .DEPTH    (DEPTH),
    .IW       (IW)
  ) u_rgen (
    .addr_i (rax_q.addr),
    .size_i (rax_q.size),
    .burst_i(rax_q.burst),
    .next_o (r_next),
    .idx_o  (r_idx),
    .resp_o (r_resp)
  );

  // rax_q.addr always holds the address of the next beat to present.
  always_comb begin
    r_state_d = r_state_q;
    rax_d     = rax_q;
    rbeat_d   = rbeat_q;
    rcnt_d    = rcnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_load    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (!arready_q) begin
          if (rcnt_q <= 8'd1) arready_d = 1'b1;
          else                rcnt_d = rcnt_q - 8'd1;
        end else if (arvalid) begin
          rax_d     = '{addr: araddr, id: arid, len: arlen,
                        size: arsize, burst: arburst};
          rbeat_d   = 8'd0;
          rcnt_d    = RLAT;
          arready_d = 1'b0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q <= 8'd1) begin
          r_load    = 1'b1;
          r_state_d = R_BURST;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
      R_BURST: begin
        if (rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = (gap == 3'd0);
            rcnt_d    = 8'(gap);
            r_state_d = R_IDLE;
          end else if (gap != 3'd0) begin
            rvalid_d  = 1'b0;
            rcnt_d    = 8'(gap);
            r_state_d = R_WAIT;
          end else begin
            r_load = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load) begin
      rvalid_d   = 1'b1;
      rresp_d    = r_resp;
      rdata_d    = (r_resp == RESP_OKAY) ? mem_q[r_idx] : 32'd0;
      rlast_d    = (rbeat_q == rax_q.len);
      rbeat_d    = rbeat_q + 8'd1;
      rax_d.addr = r_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rax_q     <= '0;
      rbeat_q   <= 8'd0;
      rcnt_q    <= 8'd0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rax_q     <= rax_d;
      rbeat_q   <= rbeat_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------- write channel ----------------
  w_state_e    w_state_q, w_state_d;
  ax_t         wax_q, wax_d;
  logic [7:0]  wbeat_q, wbeat_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [1:0]  wacc_q, wacc_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        w_we;
  logic        w_last_exp;
  logic [1:0]  w_beat_resp;
  logic [31:0] w_next;
  logic [IW-1:0] w_idx;
  logic [1:0]  w_resp;

  axi4_burst_addr_gen #(
    .BASE_ADDR(BASE_ADDR),
    .DEPTH    (DEPTH),
    .IW       (IW)
  ) u_wgen (
    .addr_i (wax_q.addr),
    .size_i (wax_q.size),
    .burst_i(wax_q.burst),
    .next_o (w_next),
    .idx_o  (w_idx),
    .resp_o (w_resp)
  );

  always_comb begin
    w_state_d   = w_state_q;
    wax_d       = wax_q;
    wbeat_d     = wbeat_q;
    wcnt_d      = wcnt_q;
    wacc_d      = wacc_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    w_we        = 1'b0;
    w_last_exp  = (wbeat_q == wax_q.len);
    w_beat_resp = w_resp;
    unique case (w_state_q)
      W_IDLE: begin
        if (!awready_q) begin
          if (wcnt_q <= 8'd1) awready_d = 1'b1;
          else                wcnt_d = wcnt_q - 8'd1;
        end else if (awvalid) begin
          wax_d     = '{addr: awaddr, id: awid, len: awlen,
                        size: awsize, burst: awburst};
          wbeat_d   = 8'd0;
          wacc_d    = RESP_OKAY;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (!wready_q) begin
          if (wcnt_q <= 8'd1) wready_d = 1'b1;
          else                wcnt_d = wcnt_q - 8'd1;
        end else if (wvalid) begin
          // A misplaced wlast is flagged but the beat still lands.
          w_we = (w_resp == RESP_OKAY);
          if (wlast != w_last_exp)
            w_beat_resp = resp_max(w_resp, RESP_SLVERR);
          wacc_d     = resp_max(wacc_q, w_beat_resp);
          wax_d.addr = w_next;
          wbeat_d    = wbeat_q + 8'd1;
          if (w_last_exp) begin
            wready_d  = 1'b0;
            wcnt_d    = WLAT;
            w_state_d = W_WAIT;
          end else if (gap != 3'd0) begin
            wready_d = 1'b0;
            wcnt_d   = 8'(gap);
          end
        end
      end
      W_WAIT: begin
        if (wcnt_q <= 8'd1) begin
          bvalid_d  = 1'b1;
          bresp_d   = wacc_q;
          w_state_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          awready_d = (gap == 3'd0);
          wcnt_d    = 8'(gap);
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      wax_q     <= '0;
      wbeat_q   <= 8'd0;
      wcnt_q    <= 8'd0;
      wacc_q    <= RESP_OKAY;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      wax_q     <= wax_d;
      wbeat_q   <= wbeat_d;
      wcnt_q    <= wcnt_d;
      wacc_q    <= wacc_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Contents survive reset; same-edge reads see the old word.
  always_ff @(posedge clock) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b])
          mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = wax_q.id;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rid     = rax_q.id;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Bench for axi4_sram_slave: directed and random bursts checked
// against a word-array reference model of the memory map.
module tb_axi4_sram_slave;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] TOP = BASE + 32'(4 * DEPTH);
  localparam int          TMO = 300;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  always #5 clock = ~clock;

  axi4_sram_slave dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] rmax(input logic [1:0] a,
                                      input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a, input int i,
                                        input logic [2:0] sz,
                                        input logic [1:0] bt);
    if (bt == 2'b00) return a;
    return a + 32'(i) * (32'd1 << sz);
  endfunction

  function automatic logic [1:0] class_of(input logic [31:0] a,
                                          input logic [2:0] sz,
                                          input logic [1:0] bt);
    if (sz > 3'd2 || bt >= 2'b10) return 2'b10;
    if (a < BASE || a >= TOP) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [9:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[11:2];
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                          input int len, input logic [2:0] sz,
                          input logic [1:0] bt, input int last_at,
                          input string tag);
    int n;
    logic [31:0] a;
    logic [1:0] r, exp_resp;
    n = 0;
    while (!awready && n < TMO) begin tick(); n++; end
    chk({tag, "_aw_wait"}, 32'(n < TMO), 32'd1);
    awaddr = addr; awid = id; awlen = 8'(len);
    awsize = sz; awburst = bt; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    exp_resp = 2'b00;
    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wvalid = 1'b1;
      wlast = (last_at < 0) ? (i == len) : (i == last_at);
      n = 0;
      while (!wready && n < TMO) begin tick(); n++; end
      if (n >= TMO) begin
        chk({tag, "_w_wait"}, 32'(n), 32'(TMO - 1));
        break;
      end
      tick();
      a = baddr(addr, i, sz, bt);
      r = class_of(a, sz, bt);
      if (r == 2'b00)
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) ref_mem[widx(a)][8*b +: 8] = wd[i][8*b +: 8];
      if (wlast != (i == len)) r = rmax(r, 2'b10);
      exp_resp = rmax(exp_resp, r);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < TMO) begin tick(); n++; end
    chk({tag, "_b_wait"}, 32'(n < TMO), 32'd1);
    chk({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
    chk({tag, "_bid"}, 32'(bid), 32'(id));
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                         input int len, input logic [2:0] sz,
                         input logic [1:0] bt, input bit tog,
                         input int exp_lat, input string tag,
                         output logic [31:0] last_d);
    int n, beat, cyc, first;
    bit held;
    logic [31:0] hd, a, ed;
    logic hl;
    logic [1:0] er;
    n = 0;
    while (!arready && n < TMO) begin tick(); n++; end
    chk({tag, "_ar_wait"}, 32'(n < TMO), 32'd1);
    araddr = addr; arid = id; arlen = 8'(len);
    arsize = sz; arburst = bt; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    beat = 0; cyc = 0; held = 1'b0; first = -1; last_d = '0;
    hd = '0; hl = 1'b0;
    while (beat <= len && cyc < TMO * 4) begin
      if (rvalid) begin
        if (first < 0) first = cyc;
        if (held) begin
          chk({tag, "_stall_data"}, rdata, hd);
          chk({tag, "_stall_last"}, 32'(rlast), 32'(hl));
        end
        rready = tog ? (cyc % 2 == 1) : 1'b1;
        if (rready) begin
          a  = baddr(addr, beat, sz, bt);
          er = class_of(a, sz, bt);
          ed = (er == 2'b00) ? ref_mem[widx(a)] : 32'd0;
          chk({tag, "_rresp"}, 32'(rresp), 32'(er));
          if (er != 2'b10) chk({tag, "_rdata"}, rdata, ed);
          chk({tag, "_rlast"}, 32'(rlast), 32'(beat == len));
          chk({tag, "_rid"}, 32'(rid), 32'(id));
          last_d = rdata;
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1; hd = rdata; hl = rlast;
        end
      end else begin
        rready = 1'b0;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    chk({tag, "_beats"}, 32'(beat), 32'(len + 1));
    chk({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(first), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] d, a;
    int n, len, len2, idx;
    logic [2:0] sz, sz2;
    logic [1:0] bt;

    // reset values
    reset = 1'b1;
    tick(); tick();
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    reset = 1'b0;
    tick();

    // fill the whole array with random words via long bursts
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(BASE + 32'(k * 1024), 4'(k), 255, 3'd2, 2'b01, -1, "fill");
    end
    do_read(BASE + 32'h3F0, 4'h9, 7, 3'd2, 2'b01, 1'b0, -1, "fill_rd", d);

    // single write then read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(BASE + 32'h10, 4'h1, 0, 3'd2, 2'b01, -1, "single");
    do_read(BASE + 32'h10, 4'h1, 0, 3'd2, 2'b01, 1'b0, 1, "single_rd", d);
    chk("single_value", d, 32'hDEADBEEF);

    // INCR burst with toggled rready
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(BASE + 32'h100, 4'h2, 3, 3'd2, 2'b01, -1, "incr");
    do_read(BASE + 32'h100, 4'h5, 3, 3'd2, 2'b01, 1'b1, 1, "incr_rd", d);
    chk("incr_last_value", d, 32'd4);

    // partial strobe
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(BASE + 32'h200, 4'h3, 0, 3'd2, 2'b01, -1, "strb_a");
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(BASE + 32'h200, 4'h3, 0, 3'd2, 2'b01, -1, "strb_b");
    do_read(BASE + 32'h200, 4'h3, 0, 3'd2, 2'b01, 1'b0, -1, "strb_rd", d);
    chk("strb_value", d, 32'h11BB33DD);

    // errors
    do_read(32'h1000_0000, 4'h6, 0, 3'd2, 2'b01, 1'b0, -1, "decerr_rd", d);
    chk("decerr_rdata", d, 32'd0);
    do_read(BASE + 32'h40, 4'h7, 3, 3'd2, 2'b10, 1'b0, -1, "wrap_rd", d);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(BASE + 32'h400, 4'h8, 3, 3'd2, 2'b01, 1, "early_last");
    do_read(BASE + 32'h400, 4'h8, 3, 3'd2, 2'b01, 1'b0, -1, "early_rd", d);
    wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(TOP - 32'd4, 4'hA, 1, 3'd2, 2'b01, -1, "edge_w");
    do_read(TOP - 32'd4, 4'hA, 1, 3'd2, 2'b01, 1'b0, -1, "edge_rd", d);
    chk("edge_oob_rdata", d, 32'd0);
    wd[0] = $urandom; ws[0] = 4'hF;
    do_write(BASE + 32'h500, 4'hB, 0, 3'd3, 2'b01, -1, "size3_w");
    do_read(BASE + 32'h500, 4'hB, 0, 3'd2, 2'b01, 1'b0, -1, "size3_rd", d);

    // read and write to one word in the same cycle
    wd[0] = 32'd0; ws[0] = 4'hF;
    do_write(BASE + 32'h300, 4'h2, 0, 3'd2, 2'b01, -1, "rbw_zero");
    n = 0;
    while (!(awready && arready) && n < TMO) begin tick(); n++; end
    chk("rbw_idle_wait", 32'(n < TMO), 32'd1);
    awaddr = BASE + 32'h300; awid = 4'h2; awlen = 8'd0;
    awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    araddr = BASE + 32'h300; arid = 4'h3; arlen = 8'd0;
    arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("rbw_wready", 32'(wready), 32'd1);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    chk("rbw_rvalid", 32'(rvalid), 32'd1);
    chk("rbw_old_data", rdata, 32'd0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < TMO) begin tick(); n++; end
    chk("rbw_bresp", 32'(bresp), 32'd0);
    tick();
    bready = 1'b0;
    ref_mem[widx(BASE + 32'h300)] = 32'hCAFEF00D;
    do_read(BASE + 32'h300, 4'h3, 0, 3'd2, 2'b01, 1'b0, -1, "rbw_rd2", d);
    chk("rbw_new_data", d, 32'hCAFEF00D);

    // reset in the middle of a write and a read burst
    a = BASE + 32'h600;
    awaddr = a; awid = 4'hC; awlen = 8'd3;
    awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = 32'h5A5A_1234; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    n = 0;
    while (!wready && n < TMO) begin tick(); n++; end
    tick();
    wvalid = 1'b0;
    ref_mem[widx(a)] = 32'h5A5A_1234;
    araddr = BASE + 32'h700; arid = 4'hD; arlen = 8'd7;
    arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < TMO) begin tick(); n++; end
    chk("mid_rvalid_seen", 32'(rvalid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rvalid", 32'(rvalid), 32'd0);
    chk("mid_bvalid", 32'(bvalid), 32'd0);
    chk("mid_wready", 32'(wready), 32'd0);
    chk("mid_rlast", 32'(rlast), 32'd0);
    chk("mid_arready", 32'(arready), 32'd1);
    chk("mid_awready", 32'(awready), 32'd1);
    do_read(a, 4'hC, 3, 3'd2, 2'b01, 1'b0, -1, "mid_rd", d);
    do_read(BASE + 32'h10, 4'h1, 0, 3'd2, 2'b01, 1'b0, -1, "mid_keep", d);
    chk("mid_keep_value", d, 32'hDEADBEEF);

    // randomized bursts
    for (int t = 0; t < 12; t++) begin
      len  = $urandom_range(0, 7);
      len2 = $urandom_range(0, 7);
      sz   = 3'($urandom_range(0, 2));
      sz2  = 3'($urandom_range(0, 2));
      bt   = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
      idx  = $urandom_range(0, DEPTH - 9);
      a    = BASE + 32'(idx * 4);
      for (int i = 0; i <= len; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'($urandom_range(0, 15));
      end
      do_write(a, 4'($urandom_range(0, 15)), len, sz, bt, -1, "rnd_w");
      do_read(a, 4'($urandom_range(0, 15)), len2, sz2, 2'b01,
              1'($urandom_range(0, 1)), -1, "rnd_r", d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
